// File: rtl/baud_gen.sv
// baud_gen: UART baud-rate generator with programmable divisor.
// The divisor is staged and changed over glitch-free at a TX bit boundary or while disabled.
// The RX counter can be resynchronised to a start-bit edge.
// Optional fractional divisor support is enabled by defining BAUD_FRAC_EN.
module baud_gen #(
  parameter int CLK_HZ       = 50000000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                 clock50,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]           div_frac,
`endif
  input  logic                 rx_resync,
  output logic                 rxclk_en,
  output logic                 txclk_en,
  output logic [DIV_WIDTH-1:0] div_active,
  output logic                 load_pending
);

  localparam int DEFAULT_DIV = CLK_HZ / (DEFAULT_BAUD * OVERSAMPLE);
  localparam int OVS_WIDTH   = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV_V = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [OVS_WIDTH-1:0] OVS_LAST      = OVS_WIDTH'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] rx_cnt_r;
  logic [DIV_WIDTH-1:0] tx_cnt_r;
  logic [OVS_WIDTH-1:0] ovs_cnt_r;
  logic [DIV_WIDTH-1:0] div_active_r;
  logic [DIV_WIDTH-1:0] staged_r;
  logic                 load_pending_r;
  logic                 rxclk_en_r;
  logic                 txclk_en_r;

  logic [DIV_WIDTH-1:0] div_m1_s;
  logic [DIV_WIDTH-1:0] rx_limit_s;
  logic [DIV_WIDTH-1:0] tx_limit_s;
  logic [DIV_WIDTH-1:0] load_val_s;
  logic                 rx_wrap_s;
  logic                 tx_wrap_s;
  logic                 tx_sched_s;
  logic                 apply_s;

`ifdef BAUD_FRAC_EN
  logic [3:0] frac_staged_r;
  logic [3:0] frac_active_r;
  logic [3:0] rx_frac_acc_r;
  logic [3:0] frac_acc_r;
  logic       rx_extra_r;
  logic       tx_extra_r;
`endif

  // Wrap detection, divisor clamp and changeover decision
  always_comb begin
    div_m1_s   = div_active_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
`ifdef BAUD_FRAC_EN
    // A fractional carry stretches the following period by one clock
    rx_limit_s = div_m1_s + {{(DIV_WIDTH-1){1'b0}}, rx_extra_r};
    tx_limit_s = div_m1_s + {{(DIV_WIDTH-1){1'b0}}, tx_extra_r};
`else
    rx_limit_s = div_m1_s;
    tx_limit_s = div_m1_s;
`endif
    rx_wrap_s  = (rx_cnt_r == rx_limit_s);
    tx_wrap_s  = (tx_cnt_r == tx_limit_s);
    tx_sched_s = enable & tx_wrap_s & (ovs_cnt_r == OVS_LAST);
    apply_s    = load_pending_r & (~enable | tx_sched_s);
    if (div_value == {DIV_WIDTH{1'b0}}) begin
      load_val_s = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      load_val_s = div_value;
    end
  end

  // Registered strobes; a resync suppresses the RX strobe of its cycle
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      rxclk_en_r <= 1'b0;
      txclk_en_r <= 1'b0;
    end else begin
      rxclk_en_r <= enable & rx_wrap_s & ~rx_resync;
      txclk_en_r <= tx_sched_s;
    end
  end

  // RX, TX and oversample counters; a divisor changeover restarts all of them
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt_r  <= {DIV_WIDTH{1'b0}};
      tx_cnt_r  <= {DIV_WIDTH{1'b0}};
      ovs_cnt_r <= {OVS_WIDTH{1'b0}};
    end else if (apply_s) begin
      rx_cnt_r  <= {DIV_WIDTH{1'b0}};
      tx_cnt_r  <= {DIV_WIDTH{1'b0}};
      ovs_cnt_r <= {OVS_WIDTH{1'b0}};
    end else begin
      if (enable) begin
        if (rx_wrap_s) begin
          rx_cnt_r <= {DIV_WIDTH{1'b0}};
        end else begin
          rx_cnt_r <= rx_cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
        if (tx_wrap_s) begin
          tx_cnt_r <= {DIV_WIDTH{1'b0}};
          if (ovs_cnt_r == OVS_LAST) begin
            ovs_cnt_r <= {OVS_WIDTH{1'b0}};
          end else begin
            ovs_cnt_r <= ovs_cnt_r + {{(OVS_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          tx_cnt_r <= tx_cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      // Resync acts even while disabled and only touches the RX phase
      if (rx_resync) begin
        rx_cnt_r <= {DIV_WIDTH{1'b0}};
      end
    end
  end

  // Divisor staging and changeover; a new load in the apply cycle stays pending
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      div_active_r   <= DEFAULT_DIV_V;
      staged_r       <= DEFAULT_DIV_V;
      load_pending_r <= 1'b0;
    end else begin
      if (apply_s) begin
        div_active_r <= staged_r;
      end
      if (div_load) begin
        staged_r       <= load_val_s;
        load_pending_r <= 1'b1;
      end else if (apply_s) begin
        load_pending_r <= 1'b0;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  // Fractional accumulators, one per divider, restarted on changeover
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      frac_staged_r <= 4'd0;
      frac_active_r <= 4'd0;
      rx_frac_acc_r <= 4'd0;
      frac_acc_r    <= 4'd0;
      rx_extra_r    <= 1'b0;
      tx_extra_r    <= 1'b0;
    end else begin
      if (div_load) begin
        frac_staged_r <= div_frac;
      end
      if (apply_s) begin
        frac_active_r <= frac_staged_r;
        rx_frac_acc_r <= 4'd0;
        frac_acc_r    <= 4'd0;
        rx_extra_r    <= 1'b0;
        tx_extra_r    <= 1'b0;
      end else if (enable) begin
        if (rx_wrap_s) begin
          {rx_extra_r, rx_frac_acc_r} <= {1'b0, rx_frac_acc_r} + {1'b0, frac_active_r};
        end
        if (tx_wrap_s) begin
          {tx_extra_r, frac_acc_r} <= {1'b0, frac_acc_r} + {1'b0, frac_active_r};
        end
      end
    end
  end
`endif

  assign rxclk_en     = rxclk_en_r;
  assign txclk_en     = txclk_en_r;
  assign div_active   = div_active_r;
  assign load_pending = load_pending_r;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: directed scenarios plus random stimulus,
// compared cycle by cycle against a position-based reference model.
`timescale 1ns/1ps
module tb_baud_gen;

  localparam int OVS         = 16;
  localparam int DW          = 16;
  localparam int EXP_DEF_DIV = 50000000 / (115200 * 16);

  logic          clock50 = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          div_load = 1'b0;
  logic [DW-1:0] div_value = '0;
  logic          rx_resync = 1'b0;
  logic          rxclk_en;
  logic          txclk_en;
  logic [DW-1:0] div_active;
  logic          load_pending;
`ifdef BAUD_FRAC_EN
  logic [3:0]    div_frac = 4'd0;
`endif

  always #10 clock50 = ~clock50;

  baud_gen dut (
    .clock50      (clock50),
    .reset_n      (reset_n),
    .enable       (enable),
    .div_load     (div_load),
    .div_value    (div_value),
`ifdef BAUD_FRAC_EN
    .div_frac     (div_frac),
`endif
    .rx_resync    (rx_resync),
    .rxclk_en     (rxclk_en),
    .txclk_en     (txclk_en),
    .div_active   (div_active),
    .load_pending (load_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the RX period and within the whole TX bit period
  int m_div, m_staged, m_rx_pos, m_tx_pos;
  bit m_pend, m_rx_en, m_tx_en;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("rxclk_en", {31'd0, rxclk_en}, {31'd0, m_rx_en});
    check_val("txclk_en", {31'd0, txclk_en}, {31'd0, m_tx_en});
    check_val("div_active", {16'd0, div_active}, m_div);
    check_val("load_pending", {31'd0, load_pending}, {31'd0, m_pend});
  endtask

  task automatic model_step(input bit en, input bit ld, input int val, input bit rs);
    int  period;
    bit  apply;
    period  = m_div * OVS;
    apply   = m_pend && (!en || (m_tx_pos == period - 1));
    m_rx_en = en && (m_rx_pos == m_div - 1) && !rs;
    m_tx_en = en && (m_tx_pos == period - 1);
    if (apply) begin
      m_div    = m_staged;
      m_rx_pos = 0;
      m_tx_pos = 0;
    end else begin
      if (en) begin
        m_rx_pos = (m_rx_pos + 1) % m_div;
        m_tx_pos = (m_tx_pos + 1) % period;
      end
      if (rs) m_rx_pos = 0;
    end
    if (ld) begin
      m_staged = (val == 0) ? 1 : val;
      m_pend   = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
  endtask

  // Drive one set of inputs (at a falling edge), advance the model, check after the rising edge
  task automatic cycle(input bit en, input bit ld, input int val, input bit rs);
    enable    = en;
    div_load  = ld;
    div_value = val[DW-1:0];
    rx_resync = rs;
    model_step(en, ld, val, rs);
    @(negedge clock50);
    check_outputs();
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(en, 1'b0, 0, 1'b0);
  endtask

  initial begin
    m_div    = EXP_DEF_DIV;
    m_staged = EXP_DEF_DIV;
    m_rx_pos = 0;
    m_tx_pos = 0;
    m_pend   = 1'b0;
    m_rx_en  = 1'b0;
    m_tx_en  = 1'b0;

    // Reset state
    repeat (3) @(negedge clock50);
    check_outputs();
    reset_n = 1'b1;

    // Default divisor: RX every 27, TX every 432
    run(900, 1'b1);

    // Load 325 mid-bit; pending until the next TX strobe, then long periods
    run(100, 1'b1);
    cycle(1'b1, 1'b1, 325, 1'b0);
    run(11000, 1'b1);

    // Back to 27 at the next TX boundary
    cycle(1'b1, 1'b1, 27, 1'b0);
    run(6000, 1'b1);

    // Resync 10 cycles after an RX strobe
    for (int i = 0; i < 100 && !m_rx_en; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    run(10, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b1);
    run(60, 1'b1);

    // Enable low for 100 cycles mid-count
    run(13, 1'b1);
    run(100, 1'b0);
    run(60, 1'b1);

    // Resync while disabled
    run(5, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    run(40, 1'b1);

    // Divisor 0 loaded while disabled: clamps to 1 and applies at once
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    run(50, 1'b1);

    // Randomized traffic with small divisors
    for (int i = 0; i < 5000; i++) begin
      cycle(($urandom % 10) != 0, ($urandom % 150) == 0,
            int'($urandom_range(0, 40)), ($urandom % 40) == 0);
    end

`ifdef BAUD_FRAC_EN
    begin
      int  cnt;
      int  total;
      int  n_long;
      int  last;
      int  strobes;
      enable    = 1'b0;
      rx_resync = 1'b0;
      div_value = 16'd27;
      div_frac  = 4'd2;
      div_load  = 1'b1;
      @(negedge clock50);
      div_load = 1'b0;
      repeat (2) @(negedge clock50);
      enable  = 1'b1;
      cnt     = 0;
      last    = -1;
      strobes = 0;
      total   = 0;
      n_long  = 0;
      while (strobes < 17 && cnt < 1000) begin
        @(negedge clock50);
        cnt++;
        if (rxclk_en) begin
          if (last >= 0) begin
            total += cnt - last;
            if (cnt - last == 28) n_long++;
          end
          last = cnt;
          strobes++;
        end
      end
      check_val("frac_strobes", strobes, 17);
      check_val("frac_total", total, 434);
      check_val("frac_long", n_long, 2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
